// File: rtl/mac_accum_8bit.sv
// Purpose : sums NTERMS unsigned 8-bit products into an ACC_W-bit accumulator with a sticky carry-out flag.
// Latency : out_valid rises the cycle after the transfer that delivers the NTERMS-th product.
// Backpr. : in_ready is held high for the whole accumulation; the result is held in DONE until out_ready.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   start               begin a new accumulation (acted on only in IDLE)
//   in_valid/in_ready   product handshake, prod is the 8-bit unsigned product
//   acc_out, ovf        accumulated sum and sticky carry-out of the current accumulation
//   out_valid/out_ready result handshake
//   busy                high whenever the block is not IDLE
module mac_accum_8bit #(
  parameter int NTERMS = 4,
  parameter int ACC_W  = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       prod,
  output logic [ACC_W-1:0] acc_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ovf,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [3:0]     cnt;
  logic [ACC_W:0] sum;
  logic           xfer;
  logic           last;

  // One spare bit on top of the accumulator captures the carry-out.
  assign sum  = {1'b0, acc_out} + {{(ACC_W-7){1'b0}}, prod};
  assign xfer = in_ready & in_valid;
  assign last = (cnt == 4'(NTERMS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Result registers are only touched by start or a transfer, so they stay
  // readable after the DONE handshake until the next accumulation begins.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_out <= '0;
      ovf     <= 1'b0;
      cnt     <= '0;
    end else if (state == IDLE && start) begin
      acc_out <= '0;
      ovf     <= 1'b0;
      cnt     <= '0;
    end else if (xfer) begin
      acc_out <= sum[ACC_W-1:0];
      ovf     <= ovf | sum[ACC_W];
      cnt     <= cnt + 4'd1;
    end
  end

endmodule
